// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter_if
// Description : Bundle of the fetch, data and memory handshake signals around
//               mem_port_arbiter. The arbiter uses the slave modport. The
//               requesters and the memory model use the master modport.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32
);
    // instruction-fetch requester
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    // load/store requester
    logic              d_req;
    logic              d_we;
    logic [1:0]        d_size;
    logic [ADDR_W-1:0] d_addr;
    logic [31:0]       d_wdata;
    logic              d_gnt;
    logic              d_rvalid;
    logic [31:0]       d_rdata;
    logic              d_err;
    // unified memory
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport slave (
        input  if_req, if_addr,
        output if_gnt, if_rvalid, if_rdata,
        input  d_req, d_we, d_size, d_addr, d_wdata,
        output d_gnt, d_rvalid, d_rdata, d_err,
        output mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport master (
        output if_req, if_addr,
        input  if_gnt, if_rvalid, if_rdata,
        output d_req, d_we, d_size, d_addr, d_wdata,
        input  d_gnt, d_rvalid, d_rdata, d_err,
        input  mem_req, mem_we, mem_be, mem_addr, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_port_arbiter
// Description : Shares one single-port word-wide memory between instruction
//               fetch and load/store. Data has priority. A saturating
//               starvation counter forces a fetch grant after
//               FETCH_STARVE_MAX contended data grants. The block derives
//               byte enables and lane-replicated write data. Read data goes
//               back to the requester that owns the transaction.
//               Optional macro MEM_MISALIGN_TRAP_EN: a misaligned data access
//               is granted but skips the memory. It completes on the next
//               cycle with d_err set.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W           = 32,
    parameter int FETCH_STARVE_MAX = 4
) (
    input  wire logic             clk,
    input  wire logic             rst_n,
    mem_port_arbiter_if.slave     bus
);
    localparam int CNT_W = (FETCH_STARVE_MAX > 0) ? $clog2(FETCH_STARVE_MAX + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(FETCH_STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t            state_q;
    logic [CNT_W-1:0]  starve_cnt_q;
    logic              mem_req_q;
    logic              mem_we_q;
    logic [3:0]        mem_be_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [31:0]       mem_wdata_q;
    logic              if_rvalid_q;
    logic [31:0]       if_rdata_q;
    logic              d_rvalid_q;
    logic [31:0]       d_rdata_q;

    logic              idle_d;
    logic              grant_d_d;
    logic              grant_if_d;
    logic [3:0]        d_be_d;
    logic [31:0]       d_wdata_d;
    logic [CNT_W-1:0]  cnt_inc_d;
    logic              unused_addr_bits;

    // The counter never exceeds CNT_MAX, so "below the limit" means "not at the limit".
    // Grants are blocked while reset is active, so every output stays 0 during reset.
    assign idle_d     = (state_q == IDLE) && rst_n;
    assign grant_d_d  = idle_d && bus.d_req && (!bus.if_req || (starve_cnt_q != CNT_MAX));
    assign grant_if_d = idle_d && bus.if_req && !grant_d_d;
    assign cnt_inc_d  = (starve_cnt_q == CNT_MAX) ? CNT_MAX : starve_cnt_q + CNT_W'(1);

    // Fetch is always word-aligned, so the low fetch address bits are unused.
    assign unused_addr_bits = &{1'b0, bus.if_addr[1:0]};

    // Byte enables and lane-replicated store data from the access size.
    always_comb begin
        d_be_d    = 4'b1111;
        d_wdata_d = bus.d_wdata;
        case (bus.d_size)
            2'b00: begin
                d_be_d    = 4'b0001 << bus.d_addr[1:0];
                d_wdata_d = {4{bus.d_wdata[7:0]}};
            end
            2'b01: begin
                d_be_d    = bus.d_addr[1] ? 4'b1100 : 4'b0011;
                d_wdata_d = {2{bus.d_wdata[15:0]}};
            end
            default: begin
                d_be_d    = 4'b1111;
                d_wdata_d = bus.d_wdata;
            end
        endcase
    end

`ifdef MEM_MISALIGN_TRAP_EN
    logic d_err_q;
    logic misalign_d;

    // A half access must be 2-byte aligned. A word access (size 1x) must be 4-byte aligned.
    assign misalign_d = ((bus.d_size == 2'b01) && bus.d_addr[0]) ||
                        (bus.d_size[1] && (bus.d_addr[1:0] != 2'b00));
    assign bus.d_err  = d_err_q;
`else
    assign bus.d_err  = 1'b0;
`endif

    // FSM: grant capture, memory transaction hold, and completion pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_be_q     <= 4'b0000;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            if_rvalid_q  <= 1'b0;
            if_rdata_q   <= '0;
            d_rvalid_q   <= 1'b0;
            d_rdata_q    <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
            d_err_q      <= 1'b0;
`endif
        end else begin
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            d_err_q     <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (grant_if_d) begin
                        starve_cnt_q <= '0;
                        mem_req_q    <= 1'b1;
                        mem_we_q     <= 1'b0;
                        mem_be_q     <= 4'b1111;
                        mem_addr_q   <= {bus.if_addr[ADDR_W-1:2], 2'b00};
                        mem_wdata_q  <= '0;
                        state_q      <= BUSY_IF;
                    end else if (grant_d_d) begin
                        if (bus.if_req) begin
                            starve_cnt_q <= cnt_inc_d;
                        end else begin
                            starve_cnt_q <= '0;
                        end
`ifdef MEM_MISALIGN_TRAP_EN
                        if (misalign_d) begin
                            // Trap: no memory cycle, complete with an error next cycle.
                            d_rvalid_q <= 1'b1;
                            d_err_q    <= 1'b1;
                            d_rdata_q  <= '0;
                            state_q    <= IDLE;
                        end else
`endif
                        begin
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= bus.d_we;
                            mem_be_q    <= d_be_d;
                            mem_addr_q  <= {bus.d_addr[ADDR_W-1:2], 2'b00};
                            mem_wdata_q <= d_wdata_d;
                            state_q     <= BUSY_D;
                        end
                    end else if (!bus.if_req) begin
                        starve_cnt_q <= '0;
                    end
                end
                BUSY_IF: begin
                    if (bus.mem_ack) begin
                        if_rvalid_q <= 1'b1;
                        if_rdata_q  <= bus.mem_rdata;
                        mem_req_q   <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                BUSY_D: begin
                    if (bus.mem_ack) begin
                        d_rvalid_q <= 1'b1;
                        d_rdata_q  <= mem_we_q ? 32'h0 : bus.mem_rdata;
                        mem_req_q  <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    mem_req_q <= 1'b0;
                    state_q   <= IDLE;
                end
            endcase
        end
    end

    assign bus.if_gnt    = grant_if_d;
    assign bus.d_gnt     = grant_d_d;
    assign bus.if_rvalid = if_rvalid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rvalid  = d_rvalid_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_port_arbiter
// Description : Directed self-checking bench for mem_port_arbiter. It covers
//               fetch, byte and half stores, loads, contention with
//               starvation, reset in mid-transaction, and misaligned access.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;
    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;

    mem_port_arbiter_if #(.ADDR_W(32)) bus ();

    mem_port_arbiter #(
        .ADDR_W           (32),
        .FETCH_STARVE_MAX (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        bus.if_req    = 1'b0;
        bus.if_addr   = '0;
        bus.d_req     = 1'b0;
        bus.d_we      = 1'b0;
        bus.d_size    = 2'b00;
        bus.d_addr    = '0;
        bus.d_wdata   = '0;
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = '0;
    endtask

    task automatic test_reset();
        drive_idle();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        #1;
        if (bus.mem_req !== 1'b0) begin $display("FAIL reset_mem_req: got %b want 0", bus.mem_req); miscompares++; end vectors++;
        if (bus.mem_be !== 4'b0000) begin $display("FAIL reset_mem_be: got %b want 0000", bus.mem_be); miscompares++; end vectors++;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin $display("FAIL reset_rvalid: got %b%b want 00", bus.if_rvalid, bus.d_rvalid); miscompares++; end vectors++;
        if (bus.d_err !== 1'b0) begin $display("FAIL reset_d_err: got %b want 0", bus.d_err); miscompares++; end vectors++;
        // A stray ack in IDLE must be ignored.
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        if (bus.if_rvalid !== 1'b0 || bus.d_rvalid !== 1'b0) begin $display("FAIL idle_ack_ignored: got %b%b want 00", bus.if_rvalid, bus.d_rvalid); miscompares++; end vectors++;
    endtask

    task automatic test_fetch();
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0104;
        #1;
        if (bus.if_gnt !== 1'b1) begin $display("FAIL fetch_gnt: got %b want 1", bus.if_gnt); miscompares++; end vectors++;
        tick();
        bus.if_req = 1'b0;
        if (bus.mem_req !== 1'b1) begin $display("FAIL fetch_mem_req: got %b want 1", bus.mem_req); miscompares++; end vectors++;
        if (bus.mem_addr !== 32'h0000_0104) begin $display("FAIL fetch_mem_addr: got %h want 00000104", bus.mem_addr); miscompares++; end vectors++;
        if (bus.mem_be !== 4'b1111 || bus.mem_we !== 1'b0) begin $display("FAIL fetch_be_we: got %b/%b want 1111/0", bus.mem_be, bus.mem_we); miscompares++; end vectors++;
        tick();
        if (bus.mem_req !== 1'b1) begin $display("FAIL fetch_req_held: got %b want 1", bus.mem_req); miscompares++; end vectors++;
        tick();
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0010_0093;
        tick();
        bus.mem_ack   = 1'b0;
        bus.mem_rdata = 32'hFFFF_FFFF;
        if (bus.if_rvalid !== 1'b1) begin $display("FAIL fetch_rvalid: got %b want 1", bus.if_rvalid); miscompares++; end vectors++;
        if (bus.if_rdata !== 32'h0010_0093) begin $display("FAIL fetch_rdata: got %h want 00100093", bus.if_rdata); miscompares++; end vectors++;
        if (bus.d_rvalid !== 1'b0) begin $display("FAIL fetch_no_d_rvalid: got %b want 0", bus.d_rvalid); miscompares++; end vectors++;
        if (bus.mem_req !== 1'b0) begin $display("FAIL fetch_req_drop: got %b want 0", bus.mem_req); miscompares++; end vectors++;
        tick();
        if (bus.if_rvalid !== 1'b0) begin $display("FAIL fetch_rvalid_pulse: got %b want 0", bus.if_rvalid); miscompares++; end vectors++;
    endtask

    // Store with ack in the first mem_req cycle (minimum latency).
    task automatic do_store(input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] exp_be,
                            input logic [31:0] exp_addr, input logic [31:0] exp_wdata);
        tick();
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_size  = size;
        bus.d_addr  = addr;
        bus.d_wdata = wdata;
        #1;
        if (bus.d_gnt !== 1'b1) begin $display("FAIL store_gnt: got %b want 1", bus.d_gnt); miscompares++; end vectors++;
        tick();
        bus.d_req = 1'b0;
        if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1) begin $display("FAIL store_req_we: got %b/%b want 1/1", bus.mem_req, bus.mem_we); miscompares++; end vectors++;
        if (bus.mem_addr !== exp_addr) begin $display("FAIL store_addr: got %h want %h", bus.mem_addr, exp_addr); miscompares++; end vectors++;
        if (bus.mem_be !== exp_be) begin $display("FAIL store_be: got %b want %b", bus.mem_be, exp_be); miscompares++; end vectors++;
        if (bus.mem_wdata !== exp_wdata) begin $display("FAIL store_wdata: got %h want %h", bus.mem_wdata, exp_wdata); miscompares++; end vectors++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        tick();
        bus.mem_ack = 1'b0;
        if (bus.d_rvalid !== 1'b1) begin $display("FAIL store_rvalid: got %b want 1", bus.d_rvalid); miscompares++; end vectors++;
        if (bus.d_rdata !== 32'h0) begin $display("FAIL store_rdata: got %h want 00000000", bus.d_rdata); miscompares++; end vectors++;
    endtask

    task automatic test_store_byte();
        do_store(2'b00, 32'h0000_2003, 32'h0000_00AB, 4'b1000, 32'h0000_2000, 32'hABAB_ABAB);
    endtask

    task automatic test_store_half();
        do_store(2'b01, 32'h0000_2002, 32'h0000_1234, 4'b1100, 32'h0000_2000, 32'h1234_1234);
    endtask

    // Byte load at offset 1 and half load at offset 0 return the raw memory word.
    task automatic test_load();
        logic [1:0]  sizes [2];
        logic [31:0] addrs [2];
        logic [3:0]  bes   [2];
        sizes = '{2'b00, 2'b01};
        addrs = '{32'h0000_3001, 32'h0000_3004};
        bes   = '{4'b0010, 4'b0011};
        for (int i = 0; i < 2; i++) begin
            tick();
            bus.d_req  = 1'b1;
            bus.d_we   = 1'b0;
            bus.d_size = sizes[i];
            bus.d_addr = addrs[i];
            tick();
            bus.d_req = 1'b0;
            if (bus.mem_be !== bes[i] || bus.mem_we !== 1'b0) begin $display("FAIL load_be_%0d: got %b/%b want %b/0", i, bus.mem_be, bus.mem_we, bes[i]); miscompares++; end vectors++;
            if (bus.mem_addr !== {addrs[i][31:2], 2'b00}) begin $display("FAIL load_addr_%0d: got %h want %h", i, bus.mem_addr, {addrs[i][31:2], 2'b00}); miscompares++; end vectors++;
            bus.mem_ack   = 1'b1;
            bus.mem_rdata = 32'hCAFE_F00D + i;
            tick();
            bus.mem_ack = 1'b0;
            if (bus.d_rvalid !== 1'b1 || bus.d_rdata !== 32'hCAFE_F00D + i) begin $display("FAIL load_rdata_%0d: got %b/%h want 1/%h", i, bus.d_rvalid, bus.d_rdata, 32'hCAFE_F00D + i); miscompares++; end vectors++;
        end
    endtask

    // Both requesters held continuously: expected grant order D,D,D,D,IF,D.
    task automatic test_contention();
        logic exp_if [6];
        logic got_if [6];
        int   n;
        exp_if = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        n = 0;
        tick();
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0100;
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_size  = 2'b10;
        bus.d_addr  = 32'h0000_5000;
        for (int cyc = 0; cyc < 60 && n < 6; cyc++) begin
            if (cyc > 0) tick();
            bus.mem_ack = bus.mem_req;
            #1;
            if (bus.mem_req === 1'b1 && (bus.if_gnt === 1'b1 || bus.d_gnt === 1'b1)) begin
                $display("FAIL busy_no_gnt: got if_gnt=%b d_gnt=%b want 0/0", bus.if_gnt, bus.d_gnt); miscompares++;
            end
            vectors++;
            if (bus.if_gnt === 1'b1 && bus.d_gnt === 1'b1) begin
                $display("FAIL dual_gnt: got 1/1 want one-hot"); miscompares++;
            end
            if (bus.if_gnt === 1'b1 || bus.d_gnt === 1'b1) begin
                got_if[n] = bus.if_gnt;
                n++;
            end
        end
        if (n < 6) begin $display("FAIL contention_timeout: got %0d grants want 6", n); miscompares++; end vectors++;
        for (int i = 0; i < 6; i++) begin
            if (i < n && got_if[i] !== exp_if[i]) begin $display("FAIL contention_order_%0d: got if=%b want if=%b", i, got_if[i], exp_if[i]); miscompares++; end
            vectors++;
        end
        tick();
        bus.if_req  = 1'b0;
        bus.d_req   = 1'b0;
        bus.mem_ack = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            bus.mem_ack = bus.mem_req;
        end
        bus.mem_ack = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        tick();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b1;
        bus.d_size = 2'b10;
        bus.d_addr = 32'h0000_4000;
        bus.d_wdata = 32'h5555_AAAA;
        tick();
        bus.d_req = 1'b0;
        if (bus.mem_req !== 1'b1) begin $display("FAIL midrst_pre_req: got %b want 1", bus.mem_req); miscompares++; end vectors++;
        #2;
        rst_n = 1'b0;
        #1;
        if (bus.mem_req !== 1'b0 || bus.mem_we !== 1'b0 || bus.mem_be !== 4'b0000) begin $display("FAIL midrst_mem: got %b/%b/%b want 0/0/0000", bus.mem_req, bus.mem_we, bus.mem_be); miscompares++; end vectors++;
        if (bus.mem_addr !== 32'h0 || bus.mem_wdata !== 32'h0) begin $display("FAIL midrst_fields: got %h/%h want 0/0", bus.mem_addr, bus.mem_wdata); miscompares++; end vectors++;
        tick();
        rst_n       = 1'b1;
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        if (bus.d_rvalid !== 1'b0 || bus.if_rvalid !== 1'b0) begin $display("FAIL midrst_late_ack: got %b%b want 00", bus.d_rvalid, bus.if_rvalid); miscompares++; end vectors++;
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h0000_0200;
        #1;
        if (bus.if_gnt !== 1'b1) begin $display("FAIL midrst_fresh_gnt: got %b want 1", bus.if_gnt); miscompares++; end vectors++;
        tick();
        bus.if_req    = 1'b0;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h1357_9BDF;
        tick();
        bus.mem_ack = 1'b0;
        if (bus.if_rvalid !== 1'b1 || bus.if_rdata !== 32'h1357_9BDF) begin $display("FAIL midrst_fresh_rdata: got %b/%h want 1/13579bdf", bus.if_rvalid, bus.if_rdata); miscompares++; end vectors++;
    endtask

    task automatic test_misalign();
        tick();
        bus.d_req  = 1'b1;
        bus.d_we   = 1'b0;
        bus.d_size = 2'b10;
        bus.d_addr = 32'h0000_2002;
        #1;
        if (bus.d_gnt !== 1'b1) begin $display("FAIL misalign_gnt: got %b want 1", bus.d_gnt); miscompares++; end vectors++;
        tick();
        bus.d_req = 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
        if (bus.mem_req !== 1'b0) begin $display("FAIL misalign_no_req: got %b want 0", bus.mem_req); miscompares++; end vectors++;
        if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b1 || bus.d_rdata !== 32'h0) begin $display("FAIL misalign_trap: got %b/%b/%h want 1/1/0", bus.d_rvalid, bus.d_err, bus.d_rdata); miscompares++; end vectors++;
        tick();
        if (bus.d_rvalid !== 1'b0 || bus.d_err !== 1'b0) begin $display("FAIL misalign_pulse: got %b/%b want 0/0", bus.d_rvalid, bus.d_err); miscompares++; end vectors++;
`else
        if (bus.mem_req !== 1'b1 || bus.mem_be !== 4'b1111) begin $display("FAIL misalign_be: got %b/%b want 1/1111", bus.mem_req, bus.mem_be); miscompares++; end vectors++;
        if (bus.mem_addr !== 32'h0000_2000) begin $display("FAIL misalign_addr: got %h want 00002000", bus.mem_addr); miscompares++; end vectors++;
        bus.mem_ack   = 1'b1;
        bus.mem_rdata = 32'h0BAD_F00D;
        tick();
        bus.mem_ack = 1'b0;
        if (bus.d_rvalid !== 1'b1 || bus.d_err !== 1'b0 || bus.d_rdata !== 32'h0BAD_F00D) begin $display("FAIL misalign_complete: got %b/%b/%h want 1/0/0badf00d", bus.d_rvalid, bus.d_err, bus.d_rdata); miscompares++; end vectors++;
`endif
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        drive_idle();
        test_reset();
        test_fetch();
        test_store_byte();
        test_store_half();
        test_load();
        test_contention();
        test_reset_mid();
        test_misalign();
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
